// File: rtl/conv_input_interface_pkg.sv
// Shared conv-layer constants: controller command codes, completion ack
// codes and the input-stage FSM state encoding, plus the state-to-ack map.
package conv_input_interface_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_PRELOAD = 2'd1,
    CMD_SHIFT   = 2'd2,
    CMD_LOAD    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ACK_IDLE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_SHIFT   = 2'd2,
    S_LOAD    = 2'd3
  } state_e;

  // Completion code reported when a command state finishes.
  function automatic ack_e fin_ack(input state_e s);
    case (s)
      S_PRELOAD: return ACK_PRELOAD_FIN;
      S_SHIFT:   return ACK_SHIFT_FIN;
      S_LOAD:    return ACK_LOAD_FIN;
      default:   return ACK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/conv_input_interface_if.sv
// Bus bundle of the conv input stage.
//   cmd         controller command pulse        (master -> slave)
//   ack         one-cycle completion code       (slave -> master)
//   mem_rd_en   feature memory read strobe      (slave -> master)
//   mem_addr    feature memory word address     (slave -> master)
//   mem_rd_data read data, one cycle after read (master -> slave)
//   win_valid   win_col holds a window column   (slave -> master)
//   win_col     K-word column, row 0 in LSBs    (slave -> master)
//   frame_done  last frame row loaded           (slave -> master)
// master = controller/memory side, slave = conv_input_interface.
interface conv_input_interface_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 8
) ();

  logic [1:0]          cmd;
  logic [1:0]          ack;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                win_valid;
  logic [K*DATA_W-1:0] win_col;
  logic                frame_done;

  modport master (
    output cmd, mem_rd_data,
    input  ack, mem_rd_en, mem_addr, win_valid, win_col, frame_done
  );

  modport slave (
    input  cmd, mem_rd_data,
    output ack, mem_rd_en, mem_addr, win_valid, win_col, frame_done
  );

endinterface

// File: rtl/conv_input_interface_line_buffer.sv
// K x IMG_W feature line buffer.
//   clk, rst_n   clock, async active-low reset (clears the array)
//   shift_up_i   row r <= row r+1 for r < K-1 (row K-1 kept, refilled by writes)
//   wr_en_i      write wr_data_i at (wr_row_i, wr_col_i)
//   rd_col_i     column selected for the combinational read
//   rd_data_c_o  K words of that column, row 0 in LSBs (0 if out of range)
module conv_input_interface_line_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 6,
  localparam int unsigned ROW_W = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_up_i,
  input  logic                wr_en_i,
  input  logic [ROW_W-1:0]    wr_row_i,
  input  logic [COL_W-1:0]    wr_col_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [COL_W-1:0]    rd_col_i,
  output logic [K*DATA_W-1:0] rd_data_c_o
);

  logic [DATA_W-1:0] buf_q [K][IMG_W];

  // Storage: shift first, a same-cycle write lands on top of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          buf_q[r][c] <= '0;
        end
      end
    end else begin
      if (shift_up_i) begin
        for (int r = 0; r < K - 1; r++) begin
          for (int c = 0; c < IMG_W; c++) begin
            buf_q[r][c] <= buf_q[r+1][c];
          end
        end
      end
      if (wr_en_i) begin
        buf_q[wr_row_i][wr_col_i] <= wr_data_i;
      end
    end
  end

  // Column read mux.
  always_comb begin
    rd_data_c_o = '0;
    if (32'(rd_col_i) < IMG_W) begin
      for (int r = 0; r < K; r++) begin
        rd_data_c_o[r*DATA_W +: DATA_W] = buf_q[r][rd_col_i];
      end
    end
  end

endmodule

// File: rtl/conv_input_interface.sv
// Conv-layer feature-map input stage. Executes PRELOAD / SHIFT / LOAD from
// the controller against a K-row line buffer filled from feature memory,
// streams K window columns per SHIFT, and returns a one-cycle ack.
//   clk, rst_n   clock, async active-low reset
//   bus          conv_input_interface_if.slave (cmd/ack, memory read port,
//                window column stream, frame_done)
//   cmd_err_o    sticky illegal-command flag, only when CONV_IN_CMD_ERR_EN
//                is defined (busy command, or SHIFT/LOAD before any PRELOAD)
module conv_input_interface
  import conv_input_interface_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 6,
  parameter int unsigned IMG_H  = 6,
  parameter int unsigned ADDR_W = 8
) (
  input logic clk,
  input logic rst_n,
  conv_input_interface_if.slave bus
`ifdef CONV_IN_CMD_ERR_EN
  ,
  output logic cmd_err_o
`endif
);

  localparam int unsigned ROW_W = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RP_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CNT_W = $clog2(K * IMG_W + 1);
  localparam int unsigned SH_W  = $clog2(K + 1);
  localparam int unsigned PIX   = IMG_W * IMG_H;

  state_e              state_q;
  logic [CNT_W-1:0]    iss_left_q;
  logic [CNT_W-1:0]    cap_left_q;
  logic                rd_pend_q;
  logic [ROW_W-1:0]    wr_row_q;
  logic [COL_W-1:0]    wr_col_q;
  logic [COL_W-1:0]    col_ptr_q;
  logic [RP_W-1:0]     row_ptr_q;
  logic [SH_W-1:0]     sh_cnt_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  ack_e                ack_q;
  logic                win_valid_q;
  logic [K*DATA_W-1:0] win_col_q;
  logic                frame_done_q;

  cmd_e                cmd_c;
  logic [ADDR_W-1:0]   row_base_c;
  logic [ADDR_W-1:0]   addr_inc_c;
  logic [RP_W-1:0]     row_next_c;
  logic [COL_W-1:0]    rd_col_c;
  logic                shift_up_c;
  logic                wr_en_c;
  logic                last_cap_c;
  logic [K*DATA_W-1:0] col_data_c;

  // Row pointer advance modulo IMG_H (inc never exceeds IMG_H).
  function automatic logic [RP_W-1:0] row_add(input logic [RP_W-1:0] r,
                                              input int unsigned inc);
    int unsigned s;
    s = 32'(r) + inc;
    return (s >= IMG_H) ? RP_W'(s - IMG_H) : RP_W'(s);
  endfunction

  assign cmd_c = cmd_e'(bus.cmd);

  // Address generation, pointer arithmetic and buffer port control.
  always_comb begin
    row_base_c = ADDR_W'(32'(row_ptr_q) * IMG_W);
    addr_inc_c = (32'(mem_addr_q) >= PIX - 1) ? '0 : mem_addr_q + ADDR_W'(1);
    row_next_c = (state_q == S_PRELOAD) ? row_add(row_ptr_q, K) : row_add(row_ptr_q, 1);
    rd_col_c   = (state_q == S_SHIFT) ? col_ptr_q + COL_W'(sh_cnt_q) : col_ptr_q;
    // LOAD makes room in row K-1 at acceptance, before any word returns.
    shift_up_c = (state_q == S_IDLE) && (cmd_c == CMD_LOAD);
    wr_en_c    = rd_pend_q && ((state_q == S_PRELOAD) || (state_q == S_LOAD));
    last_cap_c = wr_en_c && (cap_left_q == '0);
  end

  conv_input_interface_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_up_i  (shift_up_c),
    .wr_en_i     (wr_en_c),
    .wr_row_i    (wr_row_q),
    .wr_col_i    (wr_col_q),
    .wr_data_i   (bus.mem_rd_data),
    .rd_col_i    (rd_col_c),
    .rd_data_c_o (col_data_c)
  );

  // Command FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      iss_left_q   <= '0;
      cap_left_q   <= '0;
      rd_pend_q    <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      col_ptr_q    <= '0;
      row_ptr_q    <= '0;
      sh_cnt_q     <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      ack_q        <= ACK_IDLE;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ack_q        <= ACK_IDLE;
      frame_done_q <= 1'b0;
      // Read data is valid exactly one cycle after the strobe.
      rd_pend_q    <= mem_rd_en_q;
      case (state_q)
        S_IDLE: begin
          case (cmd_c)
            CMD_PRELOAD, CMD_LOAD: begin
              state_q     <= (cmd_c == CMD_PRELOAD) ? S_PRELOAD : S_LOAD;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= row_base_c;
              iss_left_q  <= (cmd_c == CMD_PRELOAD) ? CNT_W'(K * IMG_W - 1) : CNT_W'(IMG_W - 1);
              cap_left_q  <= (cmd_c == CMD_PRELOAD) ? CNT_W'(K * IMG_W - 1) : CNT_W'(IMG_W - 1);
              wr_row_q    <= (cmd_c == CMD_PRELOAD) ? '0 : ROW_W'(K - 1);
              wr_col_q    <= '0;
            end
            CMD_SHIFT: begin
              state_q     <= S_SHIFT;
              win_valid_q <= 1'b1;
              win_col_q   <= col_data_c;
              sh_cnt_q    <= SH_W'(1);
            end
            default: ;
          endcase
        end
        S_PRELOAD, S_LOAD: begin
          if (mem_rd_en_q) begin
            if (iss_left_q == '0) begin
              mem_rd_en_q <= 1'b0;
            end else begin
              iss_left_q <= iss_left_q - CNT_W'(1);
              mem_addr_q <= addr_inc_c;
            end
          end
          if (last_cap_c) begin
            state_q      <= S_IDLE;
            ack_q        <= fin_ack(state_q);
            row_ptr_q    <= row_next_c;
            col_ptr_q    <= '0;
            frame_done_q <= (row_next_c == '0);
          end else if (wr_en_c) begin
            cap_left_q <= cap_left_q - CNT_W'(1);
            if (wr_col_q == COL_W'(IMG_W - 1)) begin
              wr_col_q <= '0;
              wr_row_q <= wr_row_q + ROW_W'(1);
            end else begin
              wr_col_q <= wr_col_q + COL_W'(1);
            end
          end
        end
        S_SHIFT: begin
          if (sh_cnt_q == SH_W'(K)) begin
            state_q     <= S_IDLE;
            ack_q       <= ACK_SHIFT_FIN;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            col_ptr_q   <= (col_ptr_q == COL_W'(IMG_W - K)) ? '0 : col_ptr_q + COL_W'(1);
          end else begin
            win_col_q <= col_data_c;
            sh_cnt_q  <= sh_cnt_q + SH_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_IN_CMD_ERR_EN
  logic preloaded_q;
  logic cmd_err_q;

  // Sticky flag: command while busy, or SHIFT/LOAD with no PRELOAD seen yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preloaded_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && (cmd_c == CMD_PRELOAD)) begin
        preloaded_q <= 1'b1;
      end
      if (((state_q != S_IDLE) && (cmd_c != CMD_IDLE)) ||
          ((state_q == S_IDLE) && ((cmd_c == CMD_SHIFT) || (cmd_c == CMD_LOAD)) && !preloaded_q)) begin
        cmd_err_q <= 1'b1;
      end
    end
  end

  assign cmd_err_o = cmd_err_q;
`endif

  assign bus.ack        = ack_q;
  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;

endmodule
